block_lock_fsm: RTL and testbench

// Block-lock controller for the 64b/66b receive path (IEEE 802.3 Cl.49 lock FSM).

---
 rtl/block_lock_pkg.sv | 21 ++
 rtl/block_lock_fsm.sv | 155 +++++++++++++++
 tb/tb_block_lock_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_lock_pkg.sv
// Shared types and helpers for the 64b/66b block-lock controller.
// Sync header encodings and the lock FSM state enum live here.
package block_lock_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT    = 2'd0,
    TEST_SH      = 2'd1,
    SLIP_WAIT_ST = 2'd2
  } lock_state_t;

  // Only the two transition encodings are legal sync headers.
  function automatic logic is_valid_hdr(
    input logic [1:0] hdr
  );
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock controller for the 64b/66b receive path.
// Slips block_sync until a clean 64-header window, then guards lock.
module block_lock_fsm
  import block_lock_pkg::*;
#(
  parameter int HDR_WIDTH    = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32,
  parameter int SLIP_CNT_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  input  logic                  i_hdr_valid,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic [SLIP_CNT_W-1:0] o_slip_cnt
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SH_CNT_MAX - 1);
  localparam logic [INV_W-1:0] INV_LAST =
    INV_W'(SH_INVLD_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(SLIP_WAIT - 1);

  lock_state_t state;
  lock_state_t state_d;

  logic [CNT_W-1:0]      sh_cnt;
  logic [CNT_W-1:0]      sh_cnt_d;
  logic [INV_W-1:0]      invld_cnt;
  logic [INV_W-1:0]      invld_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_cnt_d;
  logic                  slip_d;
  logic                  lock_d;
  logic [SLIP_CNT_W-1:0] slip_cnt_d;

  logic hdr_bad;
  logic slip_hit;
  logic win_done;
  logic win_clean;

  // A bad header slips when unlocked or when it is the last straw.
  assign hdr_bad   = !is_valid_hdr(i_sync_hdr);
  assign slip_hit  = i_hdr_valid && hdr_bad &&
                     (!o_block_lock ||
                      invld_cnt == INV_LAST);
  assign win_done  = i_hdr_valid && (sh_cnt == CNT_LAST);
  assign win_clean = win_done && !hdr_bad &&
                     (invld_cnt == '0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RESET_CNT;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; slip outranks window completion.
  always_comb begin
    state_d = state;
    unique case (state)
      RESET_CNT: begin
        state_d = TEST_SH;
      end
      TEST_SH: begin
        if (slip_hit) begin
          state_d = SLIP_WAIT_ST;
        end else if (win_done) begin
          state_d = RESET_CNT;
        end
      end
      SLIP_WAIT_ST: begin
        if (wait_cnt == WAIT_LAST) begin
          state_d = RESET_CNT;
        end
      end
      default: begin
        state_d = RESET_CNT;
      end
    endcase
  end

  // Counter and output next values.
  always_comb begin
    sh_cnt_d    = sh_cnt;
    invld_cnt_d = invld_cnt;
    wait_cnt_d  = wait_cnt;
    slip_d      = 1'b0;
    lock_d      = o_block_lock;
    slip_cnt_d  = o_slip_cnt;
    unique case (state)
      RESET_CNT: begin
        sh_cnt_d    = '0;
        invld_cnt_d = '0;
        wait_cnt_d  = '0;
      end
      TEST_SH: begin
        wait_cnt_d = '0;
        if (i_hdr_valid) begin
          sh_cnt_d = sh_cnt + CNT_W'(1);
          if (hdr_bad) begin
            invld_cnt_d = invld_cnt + INV_W'(1);
          end
        end
        if (slip_hit) begin
          slip_d = 1'b1;
          lock_d = 1'b0;
          if (o_slip_cnt != '1) begin
            slip_cnt_d = o_slip_cnt + SLIP_CNT_W'(1);
          end
        end else if (win_clean) begin
          lock_d = 1'b1;
        end
      end
      SLIP_WAIT_ST: begin
        wait_cnt_d = wait_cnt + WAIT_W'(1);
      end
      default: begin
        sh_cnt_d    = '0;
        invld_cnt_d = '0;
        wait_cnt_d  = '0;
      end
    endcase
  end

  // Registered counters and outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_slip_cnt   <= '0;
    end else begin
      sh_cnt       <= sh_cnt_d;
      invld_cnt    <= invld_cnt_d;
      wait_cnt     <= wait_cnt_d;
      o_slip       <= slip_d;
      o_block_lock <= lock_d;
      o_slip_cnt   <= slip_cnt_d;
    end
  end

endmodule

// File: tb/tb_block_lock_fsm.sv
// Scoreboard bench for block_lock_fsm.
// A timestamp-based window model predicts every registered output.
module tb_block_lock_fsm;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_hdr_valid = 1'b0;
  logic [1:0] i_sync_hdr = 2'b00;
  logic       o_slip;
  logic       o_block_lock;
  logic [7:0] o_slip_cnt;

  block_lock_fsm dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_sync_hdr   (i_sync_hdr),
    .i_hdr_valid  (i_hdr_valid),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_slip_cnt   (o_slip_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       slip;
    logic       lock;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  // Model: headers count only from edge m_live onward.
  int edge_n = 0;
  bit m_lock = 0;
  bit m_slip = 0;
  int m_scnt = 0;
  int m_n    = 0;
  int m_bad  = 0;
  int m_live = 0;

  task automatic chk(input string name, input int got,
                     input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d want %0d",
                  name, got, want);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_step(input bit rst, input bit v,
                            input logic [1:0] h);
    exp_t e;
    bit bad;
    m_slip = 0;
    if (rst) begin
      m_lock = 0;
      m_scnt = 0;
      m_n    = 0;
      m_bad  = 0;
      m_live = edge_n + 2;
    end else if (v && edge_n >= m_live) begin
      bad = (h[1] == h[0]);
      m_n++;
      if (bad) m_bad++;
      if (bad && (!m_lock || m_bad == 16)) begin
        m_slip = 1;
        m_lock = 0;
        if (m_scnt < 255) m_scnt++;
        m_n    = 0;
        m_bad  = 0;
        m_live = edge_n + 2 + 32;
      end else if (m_n == 64) begin
        if (m_bad == 0) m_lock = 1;
        m_n    = 0;
        m_bad  = 0;
        m_live = edge_n + 2;
      end
    end
    e.slip = m_slip;
    e.lock = m_lock;
    e.cnt  = 8'(m_scnt);
    sb.push_back(e);
    edge_n++;
  endtask

  task automatic cycle(input bit rst, input bit v,
                       input logic [1:0] h);
    @(negedge i_clk);
    i_reset     = rst;
    i_hdr_valid = v;
    i_sync_hdr  = h;
    model_step(rst, v, h);
  endtask

  task automatic settle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic valid_run(input int n);
    int k;
    k = 0;
    while (k < n) begin
      if ($urandom_range(0, 3) != 0) begin
        cycle(0, 1, good_hdr());
        k++;
      end else begin
        cycle(0, 0, 2'b11);
      end
    end
  endtask

  // One window of 64 strobes with nbad invalid headers in
  // [0,span); returns right after the 16th invalid if any.
  task automatic window(input int nbad, input int span,
                        input bit force_last);
    bit bad [64];
    int placed;
    int sent;
    int p;
    for (int i = 0; i < 64; i++) bad[i] = 0;
    placed = 0;
    if (force_last) begin
      bad[63] = 1;
      placed  = 1;
    end
    while (placed < nbad) begin
      p = $urandom_range(0, span - 1);
      if (!bad[p]) begin
        bad[p] = 1;
        placed++;
      end
    end
    sent = 0;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 4) == 0) cycle(0, 0, 2'b00);
      cycle(0, 1, bad[i] ? bad_hdr() : good_hdr());
      if (bad[i]) sent++;
      if (sent == 16) break;
    end
  endtask

  // Monitor: pop one expectation per edge, check slip spacing.
  initial begin
    exp_t e;
    int   cyc;
    int   last;
    bit   have;
    cyc  = 0;
    last = 0;
    have = 0;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({o_slip, o_block_lock, o_slip_cnt} === e)
          passed++;
        else
          $display("FAIL sb t=%0t: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d",
                   $time, o_slip, o_block_lock, o_slip_cnt,
                   e.slip, e.lock, e.cnt);
        if (i_reset) begin
          have = 0;
        end else if (o_slip === 1'b1) begin
          if (have) begin
            total++;
            if (cyc - last >= 34) passed++;
            else $display("FAIL slip_gap: got %0d want >=34",
                          cyc - last);
          end
          have = 1;
          last = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int align;
    int k;
    int r;
    int pct;
    logic [1:0] h;

    // Reset then 64 clean headers.
    repeat (2) cycle(1, 0, 2'b00);
    repeat (2) cycle(0, 0, 2'b00);
    valid_run(63);
    settle();
    chk("p1_unlocked_at_63", o_block_lock, 0);
    valid_run(1);
    settle();
    chk("p1_lock", o_block_lock, 1);
    chk("p1_slipcnt", o_slip_cnt, 0);

    // Unlocked: 01,01,11 slips; next 33 strobes ignored.
    cycle(1, 0, 2'b00);
    repeat (2) cycle(0, 0, 2'b00);
    cycle(0, 1, 2'b01);
    cycle(0, 1, 2'b01);
    cycle(0, 1, 2'b11);
    settle();
    chk("p2_slip", o_slip, 1);
    chk("p2_slipcnt", o_slip_cnt, 1);
    repeat (33) cycle(0, 1, 2'b00);
    repeat (63) cycle(0, 1, 2'b10);
    settle();
    chk("p2_slipcnt_hold", o_slip_cnt, 1);
    chk("p2_unlocked_63", o_block_lock, 0);
    cycle(0, 1, 2'b01);
    settle();
    chk("p2_lock", o_block_lock, 1);

    // Locked: two windows of 15 invalids keep lock.
    cycle(0, 0, 2'b00);
    window(15, 63, 1);
    settle();
    chk("p3_hold1", o_block_lock, 1);
    cycle(0, 0, 2'b00);
    window(15, 64, 0);
    settle();
    chk("p3_hold2", o_block_lock, 1);
    chk("p3_noslip", o_slip_cnt, 1);

    // Locked: 16 invalids in one window drop lock.
    cycle(0, 0, 2'b00);
    window(16, 48, 0);
    settle();
    chk("p4_slip", o_slip, 1);
    chk("p4_unlock", o_block_lock, 0);

    // Reset inside the slip wait, then during a slip pulse.
    repeat (5) cycle(0, 1, 2'b00);
    cycle(1, 0, 2'b00);
    settle();
    chk("p6_rst_wait_cnt", o_slip_cnt, 0);
    chk("p6_rst_wait_lock", o_block_lock, 0);
    repeat (2) cycle(0, 0, 2'b00);
    cycle(0, 1, 2'b00);
    settle();
    chk("p6_slip_before_rst", o_slip, 1);
    cycle(1, 0, 2'b00);
    settle();
    chk("p6_rst_pulse_slip", o_slip, 0);
    chk("p6_rst_pulse_cnt", o_slip_cnt, 0);
    repeat (2) cycle(0, 0, 2'b00);
    valid_run(64);
    settle();
    chk("p6_relock1", o_block_lock, 1);
    cycle(1, 0, 2'b00);
    settle();
    chk("p6_rst_locked", o_block_lock, 0);
    repeat (2) cycle(0, 0, 2'b00);
    valid_run(64);
    settle();
    chk("p6_relock2", o_block_lock, 1);

    // Misaligned stream by 7 bits, slip looped back.
    cycle(1, 0, 2'b00);
    repeat (2) cycle(0, 0, 2'b00);
    align = 7;
    k = 0;
    while (!m_lock && k < 8000) begin
      h = (align == 0) ? good_hdr() : 2'($urandom);
      cycle(0, 1, h);
      if (m_slip) align = (align + 1) % 66;
      k++;
    end
    settle();
    chk("p5_lock", o_block_lock, 1);
    chk("p5_slips", o_slip_cnt, 59);

    // Slip counter saturation.
    cycle(1, 0, 2'b00);
    repeat (2) cycle(0, 0, 2'b00);
    k = 0;
    while (m_scnt < 255 && k < 20000) begin
      cycle(0, 1, 2'b00);
      k++;
    end
    repeat (200) cycle(0, 1, 2'b11);
    settle();
    chk("sat_cnt", o_slip_cnt, 255);

    // Random soak with varying error density.
    cycle(1, 0, 2'b00);
    pct = 0;
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) begin
        r = $urandom_range(0, 3);
        pct = (r == 0) ? 0 : (r == 1) ? 2 :
              (r == 2) ? 10 : 30;
      end
      if ($urandom_range(0, 999) < 2) begin
        cycle(1, 0, 2'b00);
      end else if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 99) < pct)
          cycle(0, 1, bad_hdr());
        else
          cycle(0, 1, good_hdr());
      end else begin
        cycle(0, 0, 2'($urandom));
      end
    end

    repeat (3) settle();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
